adder_err_monitor: RTL and testbench

// - Hardware consumer for the approximate-adder result stream: accepts {in0, in1, out0} triples from the
//   16b KS adder under test, recomputes the exact sum, accumulates error metrics over N_SAMPLES.
// - Replaces file-based output capture for on-chip ALS error characterisation; sits after the DUT.

---
 rtl/adder_err_monitor.sv | 172 +++++++++++++++++
 tb/tb_adder_err_monitor.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_err_monitor.sv
// Error-metric monitor for an approximate adder result stream: recomputes the exact sum and
// accumulates error count, max and saturating sum of |error|. Define FIRST_MISMATCH_LOG_EN for first-mismatch capture.
module adder_err_monitor #(
   parameter int WIDTH     = 16,
   parameter int N_SAMPLES = 1000000,
   parameter int CNT_W     = 20,
   parameter int ACC_W     = 40
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in0,
   input  logic [WIDTH-1:0]   in1,
   input  logic [WIDTH:0]     out0,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   sample_cnt,
   output logic [CNT_W-1:0]   err_cnt,
   output logic [WIDTH:0]     max_err,
   output logic [ACC_W-1:0]   sum_abs_err
`ifdef FIRST_MISMATCH_LOG_EN
   ,
   output logic               mm_valid,
   output logic [WIDTH-1:0]   mm_a,
   output logic [WIDTH-1:0]   mm_b,
   output logic [WIDTH:0]     mm_sum,
   output logic [CNT_W-1:0]   mm_index
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

   state_t state, state_nxt;
   logic   transfer;
   logic   clear;

   logic               s1_valid;
   logic [WIDTH-1:0]   s1_a, s1_b;
   logic [WIDTH:0]     s1_sum;
   logic               s2_valid;
   logic [WIDTH:0]     s2_diff;
   logic [WIDTH:0]     exact, diff;
   logic [ACC_W:0]     sum_wide;

`ifdef FIRST_MISMATCH_LOG_EN
   logic [CNT_W-1:0]   s1_idx, s2_idx;
   logic [WIDTH-1:0]   s2_a, s2_b;
   logic [WIDTH:0]     s2_sum;
`endif

   assign transfer = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // DRAIN ends on the edge where the last sample leaves S2, so done and the final metric land together.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      clear     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
               clear     = 1'b1;
            end
         end
         RUN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid && sample_cnt == LAST_IDX) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (!s1_valid) state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               state_nxt = RUN;
               clear     = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Compare before subtracting so the magnitude never wraps.
   assign exact    = {1'b0, s1_a} + {1'b0, s1_b};
   assign diff     = (exact >= s1_sum) ? (exact - s1_sum) : (s1_sum - exact);
   assign sum_wide = {1'b0, sum_abs_err} + (ACC_W+1)'(s2_diff);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_sum   <= '0;
         s2_valid <= 1'b0;
         s2_diff  <= '0;
      end else begin
         s1_valid <= transfer;
         if (transfer) begin
            s1_a   <= in0;
            s1_b   <= in1;
            s1_sum <= out0;
         end
         s2_valid <= s1_valid;
         s2_diff  <= diff;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         sample_cnt  <= '0;
         err_cnt     <= '0;
         max_err     <= '0;
         sum_abs_err <= '0;
      end else begin
         if (transfer) sample_cnt <= sample_cnt + 1'b1;
         if (s2_valid && s2_diff != '0) begin
            err_cnt <= err_cnt + 1'b1;
            if (s2_diff > max_err) max_err <= s2_diff;
            sum_abs_err <= sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
         end
      end
   end

`ifdef FIRST_MISMATCH_LOG_EN
   // The sample index rides alongside the triple so the logged index matches the 0-based order of acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_idx <= '0;
         s2_idx <= '0;
         s2_a   <= '0;
         s2_b   <= '0;
         s2_sum <= '0;
      end else begin
         if (transfer) s1_idx <= sample_cnt;
         s2_idx <= s1_idx;
         s2_a   <= s1_a;
         s2_b   <= s1_b;
         s2_sum <= s1_sum;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         mm_valid <= 1'b0;
         mm_a     <= '0;
         mm_b     <= '0;
         mm_sum   <= '0;
         mm_index <= '0;
      end else if (s2_valid && s2_diff != '0 && !mm_valid) begin
         mm_valid <= 1'b1;
         mm_a     <= s2_a;
         mm_b     <= s2_b;
         mm_sum   <= s2_sum;
         mm_index <= s2_idx;
      end
   end
`endif

endmodule

// File: tb/tb_adder_err_monitor.sv
// Self-checking bench for adder_err_monitor: two instances (N_SAMPLES=4 / ACC_W=40 and
// N_SAMPLES=3 / ACC_W=17) driven with directed and random triples against an arithmetic model.
module tb_adder_err_monitor;

   logic        clk = 1'b0;
   logic        rst, start4, start3, in_valid;
   logic [15:0] in0, in1;
   logic [16:0] out0;

   logic        rdy4, busy4, done4, rdy3, busy3, done3;
   logic [19:0] scnt4, ecnt4, scnt3, ecnt3;
   logic [16:0] max4, max3;
   logic [39:0] sum4;
   logic [16:0] sum3;
`ifdef FIRST_MISMATCH_LOG_EN
   logic        mmv4, mmv3;
   logic [15:0] mma4, mmb4, mma3, mmb3;
   logic [16:0] mms4, mms3;
   logic [19:0] mmi4, mmi3;
`endif

   adder_err_monitor #(.WIDTH(16), .N_SAMPLES(4), .CNT_W(20), .ACC_W(40)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid), .in_ready(rdy4),
      .in0(in0), .in1(in1), .out0(out0), .busy(busy4), .done(done4),
      .sample_cnt(scnt4), .err_cnt(ecnt4), .max_err(max4), .sum_abs_err(sum4)
`ifdef FIRST_MISMATCH_LOG_EN
      , .mm_valid(mmv4), .mm_a(mma4), .mm_b(mmb4), .mm_sum(mms4), .mm_index(mmi4)
`endif
   );

   adder_err_monitor #(.WIDTH(16), .N_SAMPLES(3), .CNT_W(20), .ACC_W(17)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .in_valid(in_valid), .in_ready(rdy3),
      .in0(in0), .in1(in1), .out0(out0), .busy(busy3), .done(done3),
      .sample_cnt(scnt3), .err_cnt(ecnt3), .max_err(max3), .sum_abs_err(sum3)
`ifdef FIRST_MISMATCH_LOG_EN
      , .mm_valid(mmv3), .mm_a(mma3), .mm_b(mmb3), .mm_sum(mms3), .mm_index(mmi3)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int a_q[$], b_q[$], o_q[$];
   logic sel = 1'b0;
   longint e_err, e_max, e_sum;

   logic        m_ready, m_done, m_busy;
   logic [19:0] m_scnt, m_ecnt;
   logic [16:0] m_max;
   logic [39:0] m_sum;
   assign m_ready = sel ? rdy3  : rdy4;
   assign m_done  = sel ? done3 : done4;
   assign m_busy  = sel ? busy3 : busy4;
   assign m_scnt  = sel ? scnt3 : scnt4;
   assign m_ecnt  = sel ? ecnt3 : ecnt4;
   assign m_max   = sel ? max3  : max4;
   assign m_sum   = sel ? 40'(sum3) : sum4;

   function automatic longint sat_limit();
      return sel ? 64'h1FFFF : ((64'd1 << 40) - 64'd1);
   endfunction

   // Reference: plain arithmetic over the queued triples of one run.
   task automatic model_run();
      longint d;
      e_err = 0; e_max = 0; e_sum = 0;
      foreach (a_q[i]) begin
         d = longint'(a_q[i]) + longint'(b_q[i]) - longint'(o_q[i]);
         if (d < 0) d = -d;
         if (d != 0) e_err++;
         if (d > e_max) e_max = d;
         e_sum += d;
         if (e_sum > sat_limit()) e_sum = sat_limit();
      end
   endtask

   task automatic push(input int a, input int b, input int o);
      a_q.push_back(a); b_q.push_back(b); o_q.push_back(o);
   endtask

   task automatic clear_q();
      a_q.delete(); b_q.delete(); o_q.delete();
   endtask

   task automatic gen_random(input int n);
      int a, b, ex, o;
      clear_q();
      for (int i = 0; i < n; i++) begin
         a  = int'($urandom_range(65535));
         b  = int'($urandom_range(65535));
         ex = a + b;
         case ($urandom_range(3))
            0: o = ex;
            1: o = ex + int'($urandom_range(300));
            2: o = ex - int'($urandom_range(300));
            default: o = int'($urandom_range(131071));
         endcase
         if (o < 0) o = 0;
         if (o > 131071) o = 131071;
         push(a, b, o);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      if (sel) start3 = 1'b1; else start4 = 1'b1;
      @(negedge clk);
      start3 = 1'b0; start4 = 1'b0;
   endtask

   task automatic feed(input int gap_pct, input int start_at, output bit ok);
      int idx = 0;
      int budget = 400;
      logic rdy_now;
      while (idx < a_q.size() && budget > 0) begin
         if (int'($urandom_range(99)) < gap_pct) in_valid = 1'b0;
         else begin
            in_valid = 1'b1;
            in0  = 16'(a_q[idx]);
            in1  = 16'(b_q[idx]);
            out0 = 17'(o_q[idx]);
         end
         start4  = (idx == start_at && !sel);
         rdy_now = m_ready;
         @(posedge clk);
         if (in_valid && rdy_now) idx++;
         @(negedge clk);
         budget--;
      end
      in_valid = 1'b0;
      start4   = 1'b0;
      ok = (idx == a_q.size());
   endtask

   task automatic wait_done(output bit ok);
      int n = 0;
      while (!m_done && n < 30) begin
         @(negedge clk);
         n++;
      end
      ok = m_done;
   endtask

   task automatic test_reset();
      rst = 1'b1; start4 = 1'b0; start3 = 1'b0; in_valid = 1'b0;
      in0 = '0; in1 = '0; out0 = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({rdy4, busy4, done4, scnt4, ecnt4, max4, sum4} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_dut4: got rdy=%b busy=%b done=%b scnt=%h ecnt=%h max=%h sum=%h expected all 0",
                  rdy4, busy4, done4, scnt4, ecnt4, max4, sum4);
      end
      checks++;
      if ({rdy3, busy3, done3, scnt3, ecnt3, max3, sum3} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_dut3: got rdy=%b busy=%b done=%b scnt=%h ecnt=%h max=%h sum=%h expected all 0",
                  rdy3, busy3, done3, scnt3, ecnt3, max3, sum3);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({rdy4, busy4} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL idle_after_reset: got rdy=%b busy=%b expected 0 0", rdy4, busy4);
      end
   endtask

   task automatic test_clean_vectors();
      bit ok, dn;
      sel = 1'b0;
      clear_q();
      push('h1, 'h2, 'h3); push('hFFFF, 'h1, 'h10000); push('h5, 'h5, 'hA); push('h0, 'h0, 'h0);
      pulse_start();
      feed(20, -1, ok);
      wait_done(dn);
      checks++;
      if (!(ok && dn)) begin errors++; $display("[TB] FAIL clean_done: got feed_ok=%0d done=%0d expected 1 1", ok, dn); end
      checks++;
      if ({m_ecnt, m_max, m_sum} !== '0) begin
         errors++;
         $display("[TB] FAIL clean_metrics: got err=%h max=%h sum=%h expected 0 0 0", m_ecnt, m_max, m_sum);
      end
      checks++;
      if (m_scnt !== 20'd4) begin errors++; $display("[TB] FAIL clean_samples: got %0d expected 4", m_scnt); end
   endtask

   task automatic test_error_vectors();
      bit ok, dn;
      sel = 1'b1;
      clear_q();
      push('h10, 'h10, 'h1F); push('h100, 'h0, 'h110); push('h7, 'h8, 'hF);
      pulse_start();
      feed(0, -1, ok);
      wait_done(dn);
      checks++;
      if (!(ok && dn)) begin errors++; $display("[TB] FAIL err_done: got feed_ok=%0d done=%0d expected 1 1", ok, dn); end
      checks++;
      if (m_ecnt !== 20'd2) begin errors++; $display("[TB] FAIL err_count: got %h expected 2", m_ecnt); end
      checks++;
      if (m_max !== 17'h10) begin errors++; $display("[TB] FAIL err_max: got %h expected 10", m_max); end
      checks++;
      if (m_sum !== 40'h11) begin errors++; $display("[TB] FAIL err_sum: got %h expected 11", m_sum); end
`ifdef FIRST_MISMATCH_LOG_EN
      checks++;
      if ({mmv3, mma3, mmb3, mms3, mmi3} !== {1'b1, 16'h10, 16'h10, 17'h1F, 20'd0}) begin
         errors++;
         $display("[TB] FAIL mm_log: got v=%b a=%h b=%h sum=%h idx=%0d expected 1 10 10 1f 0",
                  mmv3, mma3, mmb3, mms3, mmi3);
      end
`endif
   endtask

   task automatic test_saturation();
      bit ok, dn;
      sel = 1'b1;
      clear_q();
      repeat (3) push('hFFFF, 'hFFFF, 'h0);
      pulse_start();
      feed(10, -1, ok);
      wait_done(dn);
      checks++;
      if (!(ok && dn)) begin errors++; $display("[TB] FAIL sat_done: got feed_ok=%0d done=%0d expected 1 1", ok, dn); end
      checks++;
      if (m_sum !== 40'h1FFFF) begin errors++; $display("[TB] FAIL sat_sum: got %h expected 1ffff", m_sum); end
      checks++;
      if ({m_ecnt, m_max} !== {20'd3, 17'h1FFFE}) begin
         errors++;
         $display("[TB] FAIL sat_err_max: got err=%0d max=%h expected 3 1fffe", m_ecnt, m_max);
      end
   endtask

   // Six cycles of continuous valid: only four transfers, metrics 3 register stages behind the transfer.
   task automatic test_back_to_back();
      logic [5:0]  rdy_h, done_h;
      logic [19:0] ecnt_h [6];
      logic [19:0] scnt_h [6];
      int tx = 0;
      bit dn;
      sel = 1'b0;
      pulse_start();
      checks++;
      if ({m_done, m_ready, m_scnt, m_ecnt, m_max, m_sum} !== {1'b0, 1'b1, 97'd0}) begin
         errors++;
         $display("[TB] FAIL restart_from_done: got done=%b rdy=%b scnt=%h ecnt=%h max=%h sum=%h expected 0 1 0 0 0 0",
                  m_done, m_ready, m_scnt, m_ecnt, m_max, m_sum);
      end
      gen_random(6);
      o_q[0] = a_q[0] + b_q[0] + 5;
      for (int c = 0; c < 6; c++) begin
         in_valid = 1'b1;
         in0 = 16'(a_q[c]); in1 = 16'(b_q[c]); out0 = 17'(o_q[c]);
         rdy_h[c] = m_ready;
         @(posedge clk);
         if (rdy_h[c]) tx++;
         @(negedge clk);
         done_h[c] = m_done;
         ecnt_h[c] = m_ecnt;
         scnt_h[c] = m_scnt;
      end
      in_valid = 1'b0;
      checks++;
      if (tx != 4 || rdy_h !== 6'b001111) begin
         errors++;
         $display("[TB] FAIL b2b_transfers: got tx=%0d ready=%b expected 4 001111", tx, rdy_h);
      end
      checks++;
      if ({scnt_h[0], ecnt_h[0], ecnt_h[1], ecnt_h[2]} !== {20'd1, 20'd0, 20'd0, 20'd1}) begin
         errors++;
         $display("[TB] FAIL b2b_latency: got scnt0=%0d ecnt0=%0d ecnt1=%0d ecnt2=%0d expected 1 0 0 1",
                  scnt_h[0], ecnt_h[0], ecnt_h[1], ecnt_h[2]);
      end
      checks++;
      if (done_h !== 6'b100000) begin errors++; $display("[TB] FAIL b2b_done_timing: got %b expected 100000", done_h); end
      a_q.delete(5); b_q.delete(5); o_q.delete(5);
      a_q.delete(4); b_q.delete(4); o_q.delete(4);
      model_run();
      wait_done(dn);
      checks++;
      if ({m_ecnt, m_max, m_sum} !== {20'(e_err), 17'(e_max), 40'(e_sum)}) begin
         errors++;
         $display("[TB] FAIL b2b_metrics: got err=%h max=%h sum=%h expected %h %h %h", m_ecnt, m_max, m_sum, e_err, e_max, e_sum);
      end
   endtask

   task automatic test_start_ignored();
      bit ok, dn;
      sel = 1'b0;
      gen_random(4);
      model_run();
      pulse_start();
      feed(30, 2, ok);
      wait_done(dn);
      checks++;
      if (!(ok && dn) || m_scnt !== 20'd4) begin
         errors++;
         $display("[TB] FAIL start_ignored_run: got feed_ok=%0d done=%0d scnt=%0d expected 1 1 4", ok, dn, m_scnt);
      end
      checks++;
      if ({m_ecnt, m_max, m_sum} !== {20'(e_err), 17'(e_max), 40'(e_sum)}) begin
         errors++;
         $display("[TB] FAIL start_ignored_metrics: got err=%h max=%h sum=%h expected %h %h %h", m_ecnt, m_max, m_sum, e_err, e_max, e_sum);
      end
   endtask

   task automatic test_random_runs();
      bit ok, dn;
      for (int r = 0; r < 8; r++) begin
         sel = r[0];
         gen_random(sel ? 3 : 4);
         model_run();
         pulse_start();
         feed(int'($urandom_range(50)), -1, ok);
         wait_done(dn);
         checks++;
         if (!(ok && dn) || m_scnt !== 20'(a_q.size())) begin
            errors++;
            $display("[TB] FAIL random_run%0d_done: got feed_ok=%0d done=%0d scnt=%0d expected 1 1 %0d", r, ok, dn, m_scnt, a_q.size());
         end
         checks++;
         if ({m_ecnt, m_max, m_sum} !== {20'(e_err), 17'(e_max), 40'(e_sum)}) begin
            errors++;
            $display("[TB] FAIL random_run%0d_metrics: got err=%h max=%h sum=%h expected %h %h %h",
                     r, m_ecnt, m_max, m_sum, e_err, e_max, e_sum);
         end
      end
   endtask

   task automatic test_reset_midrun();
      int tx = 0;
      int budget = 50;
      bit ok, dn;
      logic rdy_now;
      sel = 1'b0;
      pulse_start();
      while (tx < 2 && budget > 0) begin
         in_valid = 1'b1;
         in0 = 16'($urandom); in1 = 16'($urandom); out0 = 17'($urandom);
         rdy_now = m_ready;
         @(posedge clk);
         if (rdy_now) tx++;
         @(negedge clk);
         budget--;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (tx != 2 || {rdy4, busy4, done4, scnt4, ecnt4, max4, sum4} !== '0) begin
         errors++;
         $display("[TB] FAIL midrun_reset: got tx=%0d rdy=%b busy=%b done=%b scnt=%h ecnt=%h max=%h sum=%h expected 2 and all 0",
                  tx, rdy4, busy4, done4, scnt4, ecnt4, max4, sum4);
      end
      repeat (4) @(negedge clk);
      checks++;
      if ({rdy4, busy4, scnt4, ecnt4} !== '0) begin
         errors++;
         $display("[TB] FAIL midrun_flushed: got rdy=%b busy=%b scnt=%h ecnt=%h expected all 0", rdy4, busy4, scnt4, ecnt4);
      end
      gen_random(4);
      model_run();
      pulse_start();
      feed(25, -1, ok);
      wait_done(dn);
      checks++;
      if (!(ok && dn) || {m_scnt, m_ecnt, m_max, m_sum} !== {20'd4, 20'(e_err), 17'(e_max), 40'(e_sum)}) begin
         errors++;
         $display("[TB] FAIL midrun_restart: got done=%0d scnt=%0d err=%h max=%h sum=%h expected 1 4 %h %h %h",
                  dn, m_scnt, m_ecnt, m_max, m_sum, e_err, e_max, e_sum);
      end
   endtask

   initial begin
      test_reset();
      test_clean_vectors();
      test_error_vectors();
      test_saturation();
      test_back_to_back();
      test_start_ignored();
      test_random_runs();
      test_reset_midrun();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
